// File: rtl/controle_tentativas_pkg.sv
// controle_tentativas_pkg: state encoding and guess widths shared by the game controller and the hint block
package controle_tentativas_pkg;
  typedef enum logic [1:0] {
    FASE_A  = 2'd0,
    FASE_B  = 2'd1,
    VITORIA = 2'd2,
    DERROTA = 2'd3
  } estado_t;
  localparam int LARG_A = 4;
  localparam int LARG_B = 3;
  localparam int LARG_R = 4;
endpackage

// File: rtl/controle_tentativas_sincroniza_botao.sv
// sincroniza_botao: synchronizes an active-low raw key, debounces it and emits one pulse per press
module sincroniza_botao #(
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_botao_n,
  output logic o_pulso
);
  localparam int LC = $clog2(DEBOUNCE_CICLOS);
  logic [1:0]    r_sync;
  logic          r_nivel;
  logic          r_pulso;
  logic [LC-1:0] r_cont;
  logic          w_muda;
  // the accepted level flips on the last of DEBOUNCE_CICLOS differing samples
  assign w_muda  = (r_sync[1] != r_nivel) && (r_cont == LC'(DEBOUNCE_CICLOS - 1));
  assign o_pulso = r_pulso;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_nivel <= 1'b1;
      r_cont  <= '0;
      r_pulso <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_botao_n};
      r_cont  <= (r_sync[1] == r_nivel || w_muda) ? '0 : r_cont + 1'b1;
      r_nivel <= w_muda ? r_sync[1] : r_nivel;
      r_pulso <= w_muda & r_nivel;
    end
  end
endmodule

// File: rtl/controle_tentativas.sv
// controle_tentativas: captures guesses on debounced key presses, runs phase A then phase B
// and tracks the remaining attempts and the win/loss flags
module controle_tentativas
  import controle_tentativas_pkg::*;
#(
  parameter int MAX_TENTATIVAS  = 8,
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_confirma_n,
  input  logic              key_reinicia_n,
  input  logic [LARG_A-1:0] sw_tentativa,
  input  logic [LARG_A-1:0] senha_a,
  input  logic [LARG_B-1:0] senha_b,
  output logic [LARG_A-1:0] tentativa_a,
  output logic [LARG_B-1:0] tentativa_b,
  output logic              fase_b_ativa,
  output logic [LARG_R-1:0] tentativas_restantes,
  output logic              venceu,
  output logic              perdeu
);
  estado_t           r_estado, w_estado;
  logic [LARG_A-1:0] r_tent_a, w_tent_a;
  logic [LARG_B-1:0] r_tent_b, w_tent_b;
  logic [LARG_R-1:0] r_rest, w_rest, w_dec;
  logic              r_fase_b, w_fase_b, r_venceu, r_perdeu;
  logic              w_pulso_confirma, w_pulso_reinicia;
  sincroniza_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_confirma (
    .clk(clk), .rst(rst), .i_botao_n(key_confirma_n), .o_pulso(w_pulso_confirma)
  );
  sincroniza_botao #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_reinicia (
    .clk(clk), .rst(rst), .i_botao_n(key_reinicia_n), .o_pulso(w_pulso_reinicia)
  );
  assign tentativa_a          = r_tent_a;
  assign tentativa_b          = r_tent_b;
  assign fase_b_ativa         = r_fase_b;
  assign tentativas_restantes = r_rest;
  assign venceu               = r_venceu;
  assign perdeu               = r_perdeu;
  assign w_dec                = (r_rest == '0) ? '0 : r_rest - 1'b1;
  // a match is checked before exhaustion so the last attempt can still win or advance
  always_comb begin
    w_estado = r_estado;
    w_tent_a = r_tent_a;
    w_tent_b = r_tent_b;
    w_rest   = r_rest;
    w_fase_b = r_fase_b;
    if (w_pulso_reinicia) begin
      w_estado = FASE_A;
      w_tent_a = '0;
      w_tent_b = '0;
      w_rest   = LARG_R'(MAX_TENTATIVAS);
      w_fase_b = 1'b0;
    end else if (w_pulso_confirma && r_estado == FASE_A) begin
      w_tent_a = sw_tentativa;
      w_rest   = w_dec;
      w_fase_b = (sw_tentativa == senha_a);
      w_estado = (sw_tentativa == senha_a) ? FASE_B : (w_dec == '0) ? DERROTA : FASE_A;
    end else if (w_pulso_confirma && r_estado == FASE_B) begin
      w_tent_b = sw_tentativa[LARG_B-1:0];
      w_rest   = w_dec;
      w_estado = (sw_tentativa[LARG_B-1:0] == senha_b) ? VITORIA : (w_dec == '0) ? DERROTA : FASE_B;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_estado <= FASE_A;
      r_tent_a <= '0;
      r_tent_b <= '0;
      r_rest   <= LARG_R'(MAX_TENTATIVAS);
      r_fase_b <= 1'b0;
      r_venceu <= 1'b0;
      r_perdeu <= 1'b0;
    end else begin
      r_estado <= w_estado;
      r_tent_a <= w_tent_a;
      r_tent_b <= w_tent_b;
      r_rest   <= w_rest;
      r_fase_b <= w_fase_b;
      r_venceu <= (w_estado == VITORIA);
      r_perdeu <= (w_estado == DERROTA);
    end
  end
endmodule

// File: tb/tb_controle_tentativas.sv
// tb_controle_tentativas: table of key presses with queued expectations, plus debounce,
// timing and asynchronous-reset sequences
module tb_controle_tentativas;
  localparam int D = 4;
  localparam int M = 3;
  logic       clk = 1'b0, rst = 1'b1, kc = 1'b1, kr = 1'b1;
  logic [3:0] sw = '0, sa = '0;
  logic [2:0] sb = '0;
  logic [3:0] tentativa_a, tentativas_restantes;
  logic [2:0] tentativa_b;
  logic       fase_b_ativa, venceu, perdeu;
  typedef struct packed {
    logic [3:0] ta;
    logic [2:0] tb;
    logic       fb;
    logic [3:0] rest;
    logic       v;
    logic       p;
  } saida_t;
  typedef struct {
    logic       c;
    logic       r;
    logic [3:0] sw;
    logic [3:0] sa;
    logic [2:0] sb;
    saida_t     e;
  } vet_t;
  vet_t   tab[19];
  saida_t fila[$];
  int     n_vec = 0, n_err = 0, lat = 0;
  controle_tentativas #(.MAX_TENTATIVAS(M), .DEBOUNCE_CICLOS(D)) dut (
    .clk(clk), .rst(rst), .key_confirma_n(kc), .key_reinicia_n(kr),
    .sw_tentativa(sw), .senha_a(sa), .senha_b(sb),
    .tentativa_a(tentativa_a), .tentativa_b(tentativa_b), .fase_b_ativa(fase_b_ativa),
    .tentativas_restantes(tentativas_restantes), .venceu(venceu), .perdeu(perdeu)
  );
  always #5 clk = ~clk;
  function automatic saida_t mk(int ta, int tb, int fb, int rest, int v, int p);
    return {4'(ta), 3'(tb), 1'(fb), 4'(rest), 1'(v), 1'(p)};
  endfunction
  function automatic saida_t obs();
    return {tentativa_a, tentativa_b, fase_b_ativa, tentativas_restantes, venceu, perdeu};
  endfunction
  task automatic aplica(input logic c, input logic r, input int hold);
    @(negedge clk);
    kc = ~c;
    kr = ~r;
    repeat (hold) @(negedge clk);
    kc = 1'b1;
    kr = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask
  task automatic compara(input string nome);
    saida_t e, a;
    a = obs();
    n_vec++;
    if (fila.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, got %h", nome, a);
    end else begin
      e = fila.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL %s: got ta=%0d tb=%0d fb=%b rest=%0d v=%b p=%b, want ta=%0d tb=%0d fb=%b rest=%0d v=%b p=%b",
                 nome, a.ta, a.tb, a.fb, a.rest, a.v, a.p, e.ta, e.tb, e.fb, e.rest, e.v, e.p);
      end
    end
  endtask
  initial begin
    tab[0]  = '{0, 1, 4'd0, 4'd9, 3'd6, mk(0, 0, 0, 3, 0, 0)};
    tab[1]  = '{1, 0, 4'd5, 4'd9, 3'd6, mk(5, 0, 0, 2, 0, 0)};
    tab[2]  = '{1, 0, 4'd9, 4'd9, 3'd6, mk(9, 0, 1, 1, 0, 0)};
    tab[3]  = '{1, 0, 4'hE, 4'd9, 3'd6, mk(9, 6, 1, 0, 1, 0)};
    tab[4]  = '{1, 0, 4'd3, 4'd9, 3'd6, mk(9, 6, 1, 0, 1, 0)};
    tab[5]  = '{1, 1, 4'd3, 4'd9, 3'd6, mk(0, 0, 0, 3, 0, 0)};
    tab[6]  = '{1, 0, 4'd7, 4'd2, 3'd6, mk(7, 0, 0, 2, 0, 0)};
    tab[7]  = '{1, 0, 4'd7, 4'd2, 3'd6, mk(7, 0, 0, 1, 0, 0)};
    tab[8]  = '{1, 0, 4'd7, 4'd2, 3'd6, mk(7, 0, 0, 0, 0, 1)};
    tab[9]  = '{1, 0, 4'd2, 4'd2, 3'd6, mk(7, 0, 0, 0, 0, 1)};
    tab[10] = '{0, 1, 4'd2, 4'd2, 3'd6, mk(0, 0, 0, 3, 0, 0)};
    tab[11] = '{1, 0, 4'd2, 4'd2, 3'd6, mk(2, 0, 1, 2, 0, 0)};
    tab[12] = '{1, 0, 4'd1, 4'd2, 3'd6, mk(2, 1, 1, 1, 0, 0)};
    tab[13] = '{1, 0, 4'd3, 4'd2, 3'd6, mk(2, 3, 1, 0, 0, 1)};
    tab[14] = '{0, 1, 4'd3, 4'd2, 3'd6, mk(0, 0, 0, 3, 0, 0)};
    tab[15] = '{1, 0, 4'd1, 4'd2, 3'd6, mk(1, 0, 0, 2, 0, 0)};
    tab[16] = '{1, 0, 4'd1, 4'd2, 3'd6, mk(1, 0, 0, 1, 0, 0)};
    tab[17] = '{1, 0, 4'd2, 4'd2, 3'd6, mk(2, 0, 1, 0, 0, 0)};
    tab[18] = '{1, 0, 4'hE, 4'd2, 3'd6, mk(2, 6, 1, 0, 1, 0)};
    #12 fila.push_back(mk(0, 0, 0, M, 0, 0));
    compara("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 19; i++) begin
      sw = tab[i].sw;
      sa = tab[i].sa;
      sb = tab[i].sb;
      fila.push_back(tab[i].e);
      aplica(tab[i].c, tab[i].r, 10);
      compara($sformatf("vec%0d", i));
    end
    // press-to-update latency: nominally 7 negedges after the key is driven low
    sa = 4'd9;
    sw = 4'd5;
    fila.push_back(mk(0, 0, 0, M, 0, 0));
    aplica(1'b0, 1'b1, 10);
    compara("reinicia_pre_latencia");
    @(negedge clk);
    kc = 1'b0;
    lat = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (tentativas_restantes !== 4'(M)) begin
        lat = i;
        break;
      end
    end
    n_vec++;
    if (lat < 6 || lat > 8) begin
      n_err++;
      $display("FAIL latencia: got %0d cycles (0 = no update), want 6..8", lat);
    end
    kc = 1'b1;
    repeat (D + 6) @(negedge clk);
    fila.push_back(mk(5, 0, 0, 2, 0, 0));
    compara("latencia_valor");
    @(negedge clk);
    kc = 1'b0;
    repeat (3) @(negedge clk);
    kc = 1'b1;
    repeat (2) @(negedge clk);
    fila.push_back(mk(5, 0, 0, 1, 0, 0));
    aplica(1'b1, 1'b0, 10);
    compara("glitch_mais_pressao");
    fila.push_back(mk(0, 0, 0, M, 0, 0));
    aplica(1'b0, 1'b1, 10);
    compara("reinicia_pre_longa");
    fila.push_back(mk(5, 0, 0, 2, 0, 0));
    aplica(1'b1, 1'b0, 20);
    compara("pressao_longa");
    fila.push_back(mk(5, 0, 0, 1, 0, 0));
    aplica(1'b1, 1'b0, 10);
    compara("pre_reset_assincrono");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 fila.push_back(mk(0, 0, 0, M, 0, 0));
    compara("reset_assincrono");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    fila.push_back(mk(5, 0, 0, 2, 0, 0));
    aplica(1'b1, 1'b0, 10);
    compara("pos_reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/controle_tentativas.md
Name: controle_tentativas

Overview:
Sequential game controller that drives the guess side of the hint interface. It captures player guesses from switches on a debounced button press and sequences phase A (4-bit secret) then phase B (3-bit secret). It supplies tentativa_a, tentativa_b and fase_b_ativa to the hint block. It also keeps the remaining-attempt budget and flags win or loss. It sits between the DE2 switches/keys and the hint/display logic.

Parameters:
MAX_TENTATIVAS, 8, attempt budget shared by both phases; legal range 1..15.
DEBOUNCE_CICLOS, 16, consecutive stable synchronized samples required before a button level is accepted; legal range 2..65535.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
key_confirma_n  input  1  raw push button, active-low, asynchronous to clk
key_reinicia_n  input  1  raw push button, active-low, asynchronous to clk
sw_tentativa  input  4  player guess switches; phase B uses bits [2:0] only
senha_a  input  4  correct secret A; quasi-static
senha_b  input  3  correct secret B; quasi-static
tentativa_a  output  4  latched last guess for A
tentativa_b  output  3  latched last guess for B
fase_b_ativa  output  1  0 = phase A, 1 = phase B or later
tentativas_restantes  output  4  remaining attempts
venceu  output  1  game won, level
perdeu  output  1  game lost, level

Behaviour:
- Reset is asynchronous and active-high. On reset the state is FASE_A and the outputs are:
  - tentativa_a = 0, tentativa_b = 0, fase_b_ativa = 0
  - tentativas_restantes = MAX_TENTATIVAS
  - venceu = 0, perdeu = 0
  - debounce filters reset to the released level (1); no pulse is generated.
- Button path, per key:
  - 2-flop synchronizer, then a debounce counter.
  - The filtered level changes only after DEBOUNCE_CICLOS consecutive synchronized samples that differ from it. Any sample equal to the current level clears the counter.
  - A falling edge of the filtered level produces a one-cycle pulse (pulso_confirma / pulso_reinicia).
  - Release generates no pulse. Holding the key produces exactly one pulse.
- The key must be low and stable from edge k; the pulse is high in cycle k+2+DEBOUNCE_CICLOS (±1 for sync metastability margin). A bench must allow a tolerance window of 1 cycle.
- FSM states: FASE_A, FASE_B, VITORIA, DERROTA. On a cycle where a pulse is high:
  - pulso_reinicia (any state; has priority over pulso_confirma in the same cycle): go to FASE_A and reload all outputs to their reset values.
  - FASE_A + pulso_confirma: latch tentativa_a = sw_tentativa and decrement restantes (saturating at 0).
    - If sw_tentativa == senha_a: go to FASE_B and set fase_b_ativa = 1.
    - Else, if the decremented value == 0: go to DERROTA.
  - FASE_B + pulso_confirma: latch tentativa_b = sw_tentativa[2:0] and decrement restantes.
    - If equal to senha_b: go to VITORIA.
    - Else, if restantes reaches 0: go to DERROTA.
  - A match has priority over exhaustion. A correct guess on the last attempt wins, or advances from phase A to phase B; entering FASE_B with restantes = 0 is legal.
  - In FASE_B with restantes = 0, a confirm still evaluates the guess and keeps restantes = 0. A match goes to VITORIA; a miss goes to DERROTA.
  - VITORIA / DERROTA: confirm is ignored and all outputs hold.
- Status flags and output updates:
  - venceu = (state == VITORIA) and perdeu = (state == DERROTA), both registered.
  - fase_b_ativa stays 1 in VITORIA and stays at its current value in DERROTA.
  - All output updates occur on the same edge that samples the pulse (1-cycle latency from pulse).
  - tentativa_a is not modified during phase B, and tentativa_b is not modified during phase A.
- rst asserted mid-debounce or mid-game returns to the reset values immediately (asynchronously).

Decomposition:
- Shared package: FSM state encoding constants (FASE_A = 2'd0, FASE_B = 2'd1, VITORIA = 2'd2, DERROTA = 2'd3) and the widths LARG_A = 4, LARG_B = 3, so the hint block and this block use the same widths.
- One sub-module, sincroniza_botao (synchronizer + debounce + falling-edge pulse, parameter DEBOUNCE_CICLOS). It is instantiated twice, once per key.

Test Plan:
Use DEBOUNCE_CICLOS = 4 and MAX_TENTATIVAS = 3 throughout.
1. rst pulse mid-run -> all outputs at reset values asynchronously; restantes = 3.
2. senha_a = 9. Press with sw = 5, then sw = 9 -> first press: tentativa_a = 5, restantes = 2, fase_b_ativa = 0. Second press: tentativa_a = 9, restantes = 1, fase_b_ativa = 1.
3. Continue from scenario 2 with senha_b = 6. Press with sw = 4'b1110 -> tentativa_b = 6, venceu = 1, restantes = 0. Further presses change nothing.
4. senha_a = 2. Press three times with sw = 7 -> restantes goes 2, 1, 0; perdeu = 1 after the third press; fase_b_ativa = 0.
5. Bouncy key: a 3-cycle low glitch, then a 10-cycle hold -> exactly one pulse and one decrement. A 20-cycle hold -> still one pulse.
6. From VITORIA, pressing confirm and reinicia in the same cycle -> FASE_A, restantes = 3, venceu = 0, tentativa_a = 0, tentativa_b = 0.
